// File: rtl/mult8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built on one 4x4 sub-multiplier.
package mult8_seq_pkg;

   localparam int SUB_W  = 4;
   localparam int PROD_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LL,
      S_HL,
      S_LH,
      S_HH,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      Q_LL = 2'd0,
      Q_HL = 2'd1,
      Q_LH = 2'd2,
      Q_HH = 2'd3
   } quarter_t;

   // Approximate mode ORs the low cross terms and only adds from weight 7 upward;
   // LL bit 7 is a compensation bit of the quarter itself and is deliberately dropped.
   function automatic logic [PROD_W-1:0] combine_quarters(
      input logic       approx,
      input logic [7:0] ll,
      input logic [7:0] hl,
      input logic [7:0] lh,
      input logic [7:0] hh
   );
      logic [8:0] upper;
      if (approx) begin
         upper = {hh, 1'b0} + {4'b0, hl[7:3]} + {4'b0, lh[7:3]};
         return {upper, ll[6:4] | hl[2:0] | lh[2:0], ll[3:0]};
      end
      return {8'b0, ll} + {4'b0, hl, 4'b0} + {4'b0, lh, 4'b0} + {hh, 8'b0};
   endfunction

endpackage

// File: rtl/mult4_cfg.sv
// Combinational 4x4 quarter-product unit; exact or approximate depending on the quarter being formed.
module mult4_cfg
   import mult8_seq_pkg::*;
(
   input  logic [SUB_W-1:0]   x,
   input  logic [SUB_W-1:0]   y,
   input  logic               approx,
   input  logic [1:0]         qsel,
   output logic [2*SUB_W-1:0] p
);

   logic [2*SUB_W-2:0] col;
   logic [2*SUB_W-1:0] exact_p;
   logic               top_hit;
   logic               next_hit;

   assign exact_p  = 8'(x) * 8'(y);
   assign top_hit  = x[3] & y[3];
   assign next_hit = x[2] & y[2];

   // Each column bit is the OR of all partial-product bits of that weight.
   always_comb begin
      col = '0;
      for (int i = 0; i < SUB_W; i++) begin
         for (int j = 0; j < SUB_W; j++) begin
            col[i+j] = col[i+j] | (x[i] & y[j]);
         end
      end
   end

   always_comb begin
      p = exact_p;
      if (approx) begin
         case (quarter_t'(qsel))
            Q_LL:       p = {1'b1, col};
            Q_HL, Q_LH: p = {top_hit & next_hit, top_hit & ~next_hit, col[5:0]};
            default:    p = exact_p;
         endcase
      end
   end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 multiplier: one quarter-product per cycle, valid/ready on both sides.
// Optional saturating completed-operation counter op_cnt enabled by MULT8_SEQ_OP_CNT_EN.
module mult8_seq_ctrl
   import mult8_seq_pkg::*;
`ifdef MULT8_SEQ_OP_CNT_EN
   #(parameter int CNT_W = 16)
`endif
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        a,
   input  logic [7:0]        b,
   input  logic              approx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] y
`ifdef MULT8_SEQ_OP_CNT_EN
   ,
   output logic [CNT_W-1:0]  op_cnt
`endif
);

   state_t           state;
   logic [7:0]       a_q;
   logic [7:0]       b_q;
   logic             approx_q;
   logic [7:0]       part_ll;
   logic [7:0]       part_hl;
   logic [7:0]       part_lh;
   logic [SUB_W-1:0] sub_x;
   logic [SUB_W-1:0] sub_y;
   logic [1:0]       sub_sel;
   logic [7:0]       sub_p;

   // Steer the registered operand nibbles into the shared sub-multiplier.
   always_comb begin
      sub_x   = a_q[3:0];
      sub_y   = b_q[3:0];
      sub_sel = Q_LL;
      case (state)
         S_HL: begin
            sub_x   = a_q[7:4];
            sub_sel = Q_HL;
         end
         S_LH: begin
            sub_y   = b_q[7:4];
            sub_sel = Q_LH;
         end
         S_HH: begin
            sub_x   = a_q[7:4];
            sub_y   = b_q[7:4];
            sub_sel = Q_HH;
         end
         default: ;
      endcase
   end

   mult4_cfg u_mult4 (
      .x      (sub_x),
      .y      (sub_y),
      .approx (approx_q),
      .qsel   (sub_sel),
      .p      (sub_p)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         y         <= '0;
         a_q       <= '0;
         b_q       <= '0;
         approx_q  <= 1'b0;
         part_ll   <= '0;
         part_hl   <= '0;
         part_lh   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= a;
                  b_q      <= b;
                  approx_q <= approx;
                  in_ready <= 1'b0;
                  state    <= S_LL;
               end
            end
            S_LL: begin
               part_ll <= sub_p;
               state   <= S_HL;
            end
            S_HL: begin
               part_hl <= sub_p;
               state   <= S_LH;
            end
            S_LH: begin
               part_lh <= sub_p;
               state   <= S_HH;
            end
            S_HH: begin
               y         <= combine_quarters(approx_q, part_ll, part_hl, part_lh, sub_p);
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               // Returning to IDLE leaves one bubble cycle before the next acceptance.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MULT8_SEQ_OP_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         op_cnt <= '0;
      end else if (out_valid && out_ready && (op_cnt != {CNT_W{1'b1}})) begin
         op_cnt <= op_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed-vector bench for mult8_seq_ctrl; with MULT8_SEQ_OP_CNT_EN it also checks a 2-bit op_cnt.
module tb_mult8_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        approx;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;

   int compared_count = 0;
   int mismatch_count = 0;
   int exp_ops        = 0;

`ifdef MULT8_SEQ_OP_CNT_EN
   logic [1:0] op_cnt;

   mult8_seq_ctrl #(.CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .approx    (approx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .op_cnt    (op_cnt)
   );
`else
   mult8_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .approx    (approx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );
`endif

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkCounter(input string tag);
`ifdef MULT8_SEQ_OP_CNT_EN
      checkOutput(tag, 32'(op_cnt), (exp_ops > 3) ? 32'd3 : 32'(exp_ops));
`else
      $display("[TB] %s: op_cnt not built", tag);
`endif
   endtask

   // Offer one operand pair; returns at the negedge right after the acceptance edge,
   // with the inputs already scrambled so late changes would show up in y.
   task automatic acceptOperand(input logic [7:0] av, input logic [7:0] bv, input logic apx);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
      a        = av;
      b        = bv;
      approx   = apx;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~av;
      b        = ~bv;
      approx   = ~apx;
   endtask

   task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                input logic apx, input logic [15:0] exp_y, input int hold);
      int lat;
      acceptOperand(av, bv, apx);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'd5);
      checkOutput({tag, "_y"}, 32'(y), 32'(exp_y));
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         a        = 8'(i * 37);
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         checkOutput({tag, "_hold_y"}, 32'(y), 32'(exp_y));
         checkOutput({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      exp_ops++;
      checkOutput({tag, "_done_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_bubble_ready"}, 32'(in_ready), 32'd1);
      checkCounter({tag, "_op_cnt"});
   endtask

   initial begin
      int seen_valid;
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      approx    = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_y", 32'(y), 32'd0);
      checkCounter("reset_op_cnt");

      // Reset while the HL quarter is being formed.
      acceptOperand(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      exp_ops = 0;
      checkOutput("rst_hl_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_hl_out_valid", 32'(out_valid), 32'd0);
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1;
      end
      checkOutput("rst_hl_no_pulse", 32'(seen_valid), 32'd0);
      applyStimulus("after_rst_3x5", 8'h03, 8'h05, 1'b0, 16'h000F, 0);

      applyStimulus("hold_a5x3c", 8'hA5, 8'h3C, 1'b0, 16'h26AC, 10);

      // Reset while a finished product waits in DONE.
      acceptOperand(8'hFF, 8'hFF, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rst_done_reached", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      exp_ops = 0;
      checkOutput("rst_done_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_done_y", 32'(y), 32'd0);
      checkOutput("rst_done_in_ready", 32'(in_ready), 32'd1);
      checkCounter("rst_done_op_cnt");

      applyStimulus("exact_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
      applyStimulus("approx_11x11", 8'h11, 8'h11, 1'b1, 16'h0111, 0);
      applyStimulus("approx_zero", 8'h00, 8'h00, 1'b1, 16'h0000, 0);
      applyStimulus("exact_12x34", 8'h12, 8'h34, 1'b0, 16'h03A8, 0);
      applyStimulus("approx_ffxff", 8'hFF, 8'hFF, 1'b1, 16'hF87F, 0);
      applyStimulus("approx_23x45", 8'h23, 8'h45, 1'b1, 16'h096F, 0);
      applyStimulus("approx_8cx0c", 8'h8C, 8'h0C, 1'b1, 16'h0670, 0);
      checkCounter("final_op_cnt_saturated");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
      $finish;
   end

endmodule
